// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding,
// default timing constants and a counter-range helper for elaboration checks.
package btn_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 20;
   localparam int DEF_HOLD_CYCLES     = 200;
   localparam int DEF_REPEAT_CYCLES   = 100;
   localparam int DEF_CNT_W           = 16;

   // True when a cycle count is at least 1 and representable in a width-bit counter.
   function automatic bit fits_cnt(input longint value, input int width);
      return (value >= 1) && (value <= ((longint'(1) << width) - 1));
   endfunction

endpackage

// File: rtl/btn_conditioner_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset, shared by the panel inputs.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic q_out
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d_in;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q_out = s2_q;

endmodule

// File: rtl/btn_conditioner.sv
// Speed push-button conditioner: synchronise, debounce, press/release pulses, long press.
// Define BTN_REPEAT_EN to auto-repeat press_pulse every REPEAT_CYCLES while long_press is high.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   if (!fits_cnt(longint'(DEBOUNCE_CYCLES), CNT_W)) begin : g_bad_debounce
      $error("btn_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
   end
   if (!fits_cnt(longint'(HOLD_CYCLES), CNT_W)) begin : g_bad_hold
      $error("btn_conditioner: HOLD_CYCLES out of range for CNT_W");
   end
   if (!fits_cnt(longint'(REPEAT_CYCLES), CNT_W)) begin : g_bad_repeat
      $error("btn_conditioner: REPEAT_CYCLES out of range for CNT_W");
   end

   logic             s2;
   logic             btn_level_q, btn_level_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   btn_state_e       state_q, state_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic             long_press_q, long_press_d;
   logic             rise_evt, fall_evt;
`ifdef BTN_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d_in  (btn_in),
      .q_out (s2)
   );

   // A level change is accepted only after s2 disagrees with it for DEBOUNCE_CYCLES edges in a row.
   always_comb begin
      dcnt_d      = dcnt_q;
      btn_level_d = btn_level_q;
      rise_evt    = 1'b0;
      fall_evt    = 1'b0;
      if (s2 == btn_level_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DEB_LAST) begin
         btn_level_d = s2;
         dcnt_d      = '0;
         rise_evt    = s2;
         fall_evt    = ~s2;
      end else if (dcnt_q != CNT_SAT) begin
         dcnt_d = dcnt_q + 1'b1;
      end
   end

   // FSM reacts to the accepted edge itself, so release_pulse and the long_press drop share an edge.
   always_comb begin
      state_d         = state_q;
      hcnt_d          = hcnt_q;
      long_press_d    = long_press_q;
      press_pulse_d   = rise_evt;
      release_pulse_d = fall_evt;
`ifdef BTN_REPEAT_EN
      rcnt_d          = rcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (rise_evt) begin
               state_d = PRESSED;
               hcnt_d  = '0;
            end
         end
         PRESSED: begin
            if (fall_evt) begin
               state_d = IDLE;
               hcnt_d  = '0;
            end else if (hcnt_q == HOLD_LAST) begin
               state_d      = HELD;
               long_press_d = 1'b1;
`ifdef BTN_REPEAT_EN
               rcnt_d       = '0;
`endif
            end else if (hcnt_q != CNT_SAT) begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         HELD: begin
            if (fall_evt) begin
               state_d      = IDLE;
               long_press_d = 1'b0;
               hcnt_d       = '0;
            end
`ifdef BTN_REPEAT_EN
            else if (rcnt_q == REP_LAST) begin
               press_pulse_d = 1'b1;
               rcnt_d        = '0;
            end else if (rcnt_q != CNT_SAT) begin
               rcnt_d = rcnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d      = IDLE;
            long_press_d = 1'b0;
            hcnt_d       = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_level_q     <= 1'b0;
         dcnt_q          <= '0;
         hcnt_q          <= '0;
         state_q         <= IDLE;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_press_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
         rcnt_q          <= '0;
`endif
      end else begin
         btn_level_q     <= btn_level_d;
         dcnt_q          <= dcnt_d;
         hcnt_q          <= hcnt_d;
         state_q         <= state_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_press_q    <= long_press_d;
`ifdef BTN_REPEAT_EN
         rcnt_q          <= rcnt_d;
`endif
      end
   end

   assign btn_level     = btn_level_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_press    = long_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random button
// activity compared every cycle against a sample-history reference model.
module tb_btn_conditioner;

   localparam int DEB  = 20;
   localparam int HOLD = 200;
   localparam int REP  = 100;
   localparam int CW   = 16;
`ifdef BTN_REPEAT_EN
   localparam int EXP_LONG_HOLD_PRESSES = 5;
`else
   localparam int EXP_LONG_HOLD_PRESSES = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic btn_level, press_pulse, release_pulse, long_press;

   int assert_count  = 0;
   int fail_count    = 0;
   int press_count   = 0;
   int release_count = 0;
   bit speed_sel     = 1'b0;

   // Reference model state: synchroniser taps, recent s2 history, accepted level.
   bit m_s1, m_s2, m_level;
   bit s2_hist[$];
   int edge_n      = 0;
   int m_rise_edge = 0;
   bit exp_level, exp_press, exp_release, exp_long;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .REPEAT_CYCLES   (REP),
      .CNT_W           (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Level flips once the last DEB synchronised samples all disagree with it.
   task automatic modelStep(input bit b, input bit r);
      bit s2_seen;
      bit flip;
      int held;
      if (r) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         m_level = 1'b0;
         s2_hist.delete();
         exp_press = 1'b0;
         exp_release = 1'b0;
         exp_long = 1'b0;
      end else begin
         s2_seen = m_s2;
         m_s2 = m_s1;
         m_s1 = b;
         s2_hist.push_back(s2_seen);
         if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
         flip = (s2_hist.size() == DEB);
         foreach (s2_hist[i]) if (s2_hist[i] == m_level) flip = 1'b0;
         exp_press = 1'b0;
         exp_release = 1'b0;
         if (flip) begin
            m_level = ~m_level;
            if (m_level) begin
               exp_press = 1'b1;
               m_rise_edge = edge_n;
            end else begin
               exp_release = 1'b1;
            end
         end
         held = edge_n - m_rise_edge;
         exp_long = m_level && (held >= HOLD);
`ifdef BTN_REPEAT_EN
         if (m_level && (held > HOLD) && (((held - HOLD) % REP) == 0)) exp_press = 1'b1;
`endif
      end
      exp_level = m_level;
      edge_n++;
   endtask

   task automatic checkOutput();
      checkValue("btn_level", btn_level, exp_level);
      checkValue("press_pulse", press_pulse, exp_press);
      checkValue("release_pulse", release_pulse, exp_release);
      checkValue("long_press", long_press, exp_long);
      checkValue("pulse_exclusive", press_pulse & release_pulse, 0);
   endtask

   task automatic applyStimulus(input bit b, input bit r);
      btn_in = b;
      reset  = r;
      @(posedge clk);
      modelStep(b, r);
      #1;
      checkOutput();
      if (press_pulse === 1'b1) begin
         press_count++;
         speed_sel = ~speed_sel;
      end
      if (release_pulse === 1'b1) release_count++;
   endtask

   initial begin
      int len;
      bit val;
      bit rst;

      btn_in = 1'b0;
      reset  = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
      checkValue("reset_level", btn_level, 0);
      checkValue("reset_long", long_press, 0);
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);

      // Clean step: level and press appear on edge E0+21, one cycle wide.
      press_count = 0;
      for (int i = 0; i < 21; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t1_level_before", btn_level, 0);
      applyStimulus(1'b1, 1'b0);
      checkValue("t1_level_at_21", btn_level, 1);
      checkValue("t1_press_at_21", press_pulse, 1);
      applyStimulus(1'b1, 1'b0);
      checkValue("t1_press_width", press_pulse, 0);
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t1_press_count", press_count, 1);
      release_count = 0;
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);
      checkValue("t1_release_count", release_count, 1);

      // Bounce every 3 cycles for 30 cycles, then steady high.
      press_count = 0;
      for (int seg = 0; seg < 10; seg++)
         for (int k = 0; k < 3; k++) applyStimulus(((seg % 2) == 0), 1'b0);
      for (int i = 0; i < 21; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t2_no_pulse_in_bounce", press_count, 0);
      applyStimulus(1'b1, 1'b0);
      checkValue("t2_press_after_bounce", press_pulse, 1);
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t2_press_count", press_count, 1);
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);

      // Long press: 200 cycles after level; drops with release_pulse.
      for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t3_level_up", btn_level, 1);
      for (int i = 0; i < 199; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t3_long_before", long_press, 0);
      applyStimulus(1'b1, 1'b0);
      checkValue("t3_long_at_200", long_press, 1);
      for (int i = 0; i < 179; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 21; i++) applyStimulus(1'b0, 1'b0);
      checkValue("t3_long_before_release", long_press, 1);
      applyStimulus(1'b0, 1'b0);
      checkValue("t3_release_pulse", release_pulse, 1);
      checkValue("t3_long_drops", long_press, 0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);

      // Hold 450 cycles past long_press.
      press_count = 0;
      for (int i = 0; i < 650; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);
      checkValue("t4_press_count", press_count, EXP_LONG_HOLD_PRESSES);

      // Reset while HELD, button still down afterwards.
      for (int i = 0; i < 250; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t5_long_before_reset", long_press, 1);
      applyStimulus(1'b1, 1'b1);
      checkValue("t5_level_reset", btn_level, 0);
      checkValue("t5_long_reset", long_press, 0);
      checkValue("t5_press_reset", press_pulse, 0);
      checkValue("t5_release_reset", release_pulse, 0);
      applyStimulus(1'b1, 1'b1);
      press_count = 0;
      for (int i = 0; i < 21; i++) applyStimulus(1'b1, 1'b0);
      checkValue("t5_no_early_press", press_count, 0);
      applyStimulus(1'b1, 1'b0);
      checkValue("t5_press_after_reset", press_pulse, 1);
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);

      // Downstream selector toggles once per short press.
      press_count = 0;
      speed_sel = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0);
         for (int i = 0; i < 950; i++) applyStimulus(1'b0, 1'b0);
      end
      checkValue("t6_toggle_count", press_count, 2);
      checkValue("t6_speed_sel", speed_sel, 0);

      // Random runs of button activity, occasional long holds and resets.
      for (int run = 0; run < 150; run++) begin
         val = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 450))
                                           : int'($urandom_range(1, 40));
         rst = ($urandom_range(0, 49) == 0);
         for (int k = 0; k < len; k++) applyStimulus(val, rst && (k < 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
